// File: rtl/serpent_xts_pkg.sv
// Shared definitions for the Serpent XTS sequencer: FSM encodings and the GF(2^128) reduction constant.
package serpent_xts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TKEY    = 3'd1,
        ST_TENC    = 3'd2,
        ST_DKEY    = 3'd3,
        ST_WAIT_IN = 3'd4,
        ST_DENC    = 3'd5,
        ST_OUT     = 3'd6,
        ST_DONE    = 3'd7
    } xts_state_e;

    localparam logic [7:0] XTS_POLY = 8'h87;

endpackage

// File: rtl/xts_gf_double.sv
// XTS tweak multiply-by-alpha in GF(2^128), little-endian byte order (byte0 = t[127:120]).
// Latency: purely combinational.
// Backpressure: none.
module xts_gf_double
    import serpent_xts_pkg::*;
(
    input  logic [127:0] t,
    output logic [127:0] t_dbl
);

    logic [127:0] le;
    logic [127:0] sh;

    always_comb begin
        le    = '0;
        sh    = '0;
        t_dbl = '0;
        // Reorder so byte i sits at le[8i+:8]; the shift then carries byte i bit7 into byte i+1 bit0.
        for (int i = 0; i < 16; i++) begin
            le[8*i +: 8] = t[127-8*i -: 8];
        end
        sh = {le[126:0], 1'b0};
        sh[7:0] = sh[7:0] ^ (le[127] ? XTS_POLY : 8'h00);
        for (int i = 0; i < 16; i++) begin
            t_dbl[127-8*i -: 8] = sh[8*i +: 8];
        end
    end

endmodule

// File: rtl/serpent_xts_seq.sv
// Sequences an external Serpent core through one XTS data unit: tweak encrypt, then per-block XEX.
// Latency: 1 cycle start->key request, core latency + 1 per stage, one block in flight at a time.
// Backpressure: o_din_ready only in WAIT_IN; o_dout held stable until i_dout_ready.
module serpent_xts_seq
    import serpent_xts_pkg::*;
#(
    parameter int MAX_BLK_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_decrypt,
    input  logic [511:0]         i_key,
    input  logic [127:0]         i_tweak,
    input  logic [MAX_BLK_W-1:0] i_nblocks,
    input  logic                 i_din_valid,
    input  logic [127:0]         i_din,
    output logic                 o_din_ready,
    output logic                 o_dout_valid,
    output logic [127:0]         o_dout,
    input  logic                 i_dout_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_core_key_valid,
    output logic [255:0]         o_core_key,
    input  logic                 i_core_key_ready,
    output logic                 o_core_start,
    output logic                 o_core_decrypt,
    output logic [127:0]         o_core_data,
    input  logic [127:0]         i_core_data,
    input  logic                 i_core_valid
);

    xts_state_e           state;
    logic [255:0]         k1_l;
    logic [127:0]         tweak_l;
    logic                 dec_l;
    logic [MAX_BLK_W-1:0] nblk_l;
    logic [MAX_BLK_W-1:0] cnt;
    logic [127:0]         t_reg;
    logic [127:0]         t_nxt;

    xts_gf_double u_dbl (
        .t     (t_reg),
        .t_dbl (t_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            k1_l             <= '0;
            tweak_l          <= '0;
            dec_l            <= 1'b0;
            nblk_l           <= '0;
            cnt              <= '0;
            t_reg            <= '0;
            o_din_ready      <= 1'b0;
            o_dout_valid     <= 1'b0;
            o_dout           <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_core_key_valid <= 1'b0;
            o_core_key       <= '0;
            o_core_start     <= 1'b0;
            o_core_decrypt   <= 1'b0;
            o_core_data      <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            o_core_start     <= 1'b0;
            o_core_key_valid <= 1'b0;
            o_done           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        k1_l             <= i_key[511:256];
                        tweak_l          <= i_tweak;
                        dec_l            <= i_decrypt;
                        nblk_l           <= (i_nblocks == '0) ? MAX_BLK_W'(1) : i_nblocks;
                        cnt              <= '0;
                        o_busy           <= 1'b1;
                        o_core_key       <= i_key[255:0];
                        o_core_key_valid <= 1'b1;
                        state            <= ST_TKEY;
                    end
                end
                ST_TKEY: begin
                    if (i_core_key_ready) begin
                        o_core_start   <= 1'b1;
                        o_core_decrypt <= 1'b0;
                        o_core_data    <= tweak_l;
                        state          <= ST_TENC;
                    end
                end
                ST_TENC: begin
                    if (i_core_valid) begin
                        t_reg            <= i_core_data;
                        o_core_key       <= k1_l;
                        o_core_key_valid <= 1'b1;
                        state            <= ST_DKEY;
                    end
                end
                ST_DKEY: begin
                    if (i_core_key_ready) begin
                        o_din_ready <= 1'b1;
                        state       <= ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    if (i_din_valid) begin
                        o_din_ready    <= 1'b0;
                        o_core_start   <= 1'b1;
                        o_core_decrypt <= dec_l;
                        o_core_data    <= i_din ^ t_reg;
                        state          <= ST_DENC;
                    end
                end
                ST_DENC: begin
                    if (i_core_valid) begin
                        o_dout       <= i_core_data ^ t_reg;
                        o_dout_valid <= 1'b1;
                        state        <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_dout_ready) begin
                        o_dout_valid <= 1'b0;
                        t_reg        <= t_nxt;
                        cnt          <= cnt + 1'b1;
                        if (cnt == nblk_l - 1'b1) begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            o_din_ready <= 1'b1;
                            state       <= ST_WAIT_IN;
                        end
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serpent_xts_seq.sv
// Directed bench for serpent_xts_seq with a swap/xor stand-in for the Serpent core.
module tb_serpent_xts_seq;

    localparam int MAX_BLK_W = 6;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_decrypt = 1'b0;
    logic [511:0]         i_key = '0;
    logic [127:0]         i_tweak = '0;
    logic [MAX_BLK_W-1:0] i_nblocks = '0;
    logic                 i_din_valid = 1'b0;
    logic [127:0]         i_din = '0;
    logic                 o_din_ready;
    logic                 o_dout_valid;
    logic [127:0]         o_dout;
    logic                 i_dout_ready = 1'b0;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_core_key_valid;
    logic [255:0]         o_core_key;
    logic                 key_rdy = 1'b1;
    logic                 o_core_start;
    logic                 o_core_decrypt;
    logic [127:0]         o_core_data;
    logic                 core_vld = 1'b0;
    logic [127:0]         core_dat = '0;
    logic                 spur_vld = 1'b0;
    logic [127:0]         spur_dat = '0;
    wire                  core_valid_w = core_vld | spur_vld;
    wire  [127:0]         core_data_w  = spur_vld ? spur_dat : core_dat;

    logic [127:0]         gf_in = '0;
    wire  [127:0]         gf_out;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int kv_cnt = 0;

    localparam logic [511:0] KEY_A = {256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000,
                                      256'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0_0011_2233_4455_6677_8899_aabb_ccdd_eeff};
    localparam logic [511:0] KEY_B = {256'hdead_beef_cafe_f00d_0123_4567_89ab_cdef_fedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c,
                                      256'h8000_0000_0000_0001_7fff_ffff_ffff_fffe_1357_9bdf_2468_ace0_0000_ffff_ffff_0000};
    localparam logic [127:0] TW_A = 128'h0000_0000_0000_0005_0000_0000_0000_0000;
    localparam logic [127:0] TW_B = 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100;

    serpent_xts_seq #(.MAX_BLK_W(MAX_BLK_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_decrypt        (i_decrypt),
        .i_key            (i_key),
        .i_tweak          (i_tweak),
        .i_nblocks        (i_nblocks),
        .i_din_valid      (i_din_valid),
        .i_din            (i_din),
        .o_din_ready      (o_din_ready),
        .o_dout_valid     (o_dout_valid),
        .o_dout           (o_dout),
        .i_dout_ready     (i_dout_ready),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_core_key_valid (o_core_key_valid),
        .o_core_key       (o_core_key),
        .i_core_key_ready (key_rdy),
        .o_core_start     (o_core_start),
        .o_core_decrypt   (o_core_decrypt),
        .o_core_data      (o_core_data),
        .i_core_data      (core_data_w),
        .i_core_valid     (core_valid_w)
    );

    xts_gf_double u_gf (
        .t     (gf_in),
        .t_dbl (gf_out)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [127:0] m_enc(input logic [255:0] k, input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ k[127:0];
    endfunction

    function automatic logic [127:0] m_dec(input logic [255:0] k, input logic [127:0] x);
        logic [127:0] y;
        y = x ^ k[127:0];
        return {y[63:0], y[127:64]};
    endfunction

    function automatic logic [127:0] ref_dbl(input logic [127:0] t);
        logic [7:0]   b [16];
        logic         c;
        logic         nc;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nc   = b[i][7];
            b[i] = {b[i][6:0], c};
            c    = nc;
        end
        if (c) b[0] = b[0] ^ 8'h87;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    // Core stand-in: latches key on key_valid, answers each start three cycles later.
    logic [255:0] mkey = '0;
    logic [127:0] mres = '0;
    int           pend = 0;
    always @(negedge i_clk) begin
        core_vld = 1'b0;
        if (o_done) done_cnt++;
        if (o_core_key_valid) begin
            kv_cnt++;
            mkey = o_core_key;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                core_vld = 1'b1;
                core_dat = mres;
            end
        end
        if (o_core_start) begin
            mres = o_core_decrypt ? m_dec(mkey, o_core_data) : m_enc(mkey, o_core_data);
            pend = 3;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_sig(input string tag, input int sel);
        logic hit;
        hit = (sel == 0) ? o_din_ready : o_dout_valid;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge i_clk);
            hit = (sel == 0) ? o_din_ready : o_dout_valid;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_din_rdy"}, o_din_ready, 0);
        chk({tag, "_dout_vld"}, o_dout_valid, 0);
        chk({tag, "_dout"}, o_dout, 0);
        chk({tag, "_key_vld"}, o_core_key_valid, 0);
        chk({tag, "_key"}, o_core_key, 0);
        chk({tag, "_cstart"}, o_core_start, 0);
        chk({tag, "_cdec"}, o_core_decrypt, 0);
        chk({tag, "_cdata"}, o_core_data, 0);
    endtask

    task automatic run_unit(input string nm, input logic dec, input logic [511:0] key,
                            input logic [127:0] tw, input logic [5:0] nb,
                            input int stall_blk, input bit disturb);
        logic [127:0] t;
        logic [127:0] din;
        logic [127:0] cc;
        logic [127:0] exp;
        int           nbe;
        int           d0;
        int           k0;
        nbe = (nb == 0) ? 1 : int'(nb);
        t   = m_enc(key[255:0], tw);
        d0  = done_cnt;
        k0  = kv_cnt;
        @(negedge i_clk);
        i_start = 1'b1; i_decrypt = dec; i_key = key; i_tweak = tw; i_nblocks = nb;
        @(negedge i_clk);
        // Scramble inputs after the start cycle so only latched values can be right.
        i_start = 1'b0; i_decrypt = ~dec; i_key = ~key; i_tweak = ~tw; i_nblocks = nb + 6'd3;
        chk({nm, "_busy"}, o_busy, 1);
        for (int b = 0; b < nbe; b++) begin
            wait_sig({nm, "_din_rdy"}, 0);
            if (disturb && b == 0) begin
                spur_vld = 1'b1; spur_dat = ~t; i_start = 1'b1;
                @(negedge i_clk);
                spur_vld = 1'b0; i_start = 1'b0;
                chk({nm, "_spur_din_rdy"}, o_din_ready, 1);
                chk({nm, "_spur_dout_vld"}, o_dout_valid, 0);
                chk({nm, "_spur_cstart"}, o_core_start, 0);
            end
            din = {32'ha5a5_0000 + 32'(b), 32'h0123_4567, 32'h89ab_cdef ^ 32'(b * 7), 32'h5a5a_5a5a};
            i_din = din; i_din_valid = 1'b1;
            @(negedge i_clk);
            i_din_valid = 1'b0;
            chk({nm, "_cstart"}, o_core_start, 1);
            chk({nm, "_cdata"}, o_core_data, din ^ t);
            chk({nm, "_cdec"}, o_core_decrypt, dec);
            cc  = dec ? m_dec(key[511:256], din ^ t) : m_enc(key[511:256], din ^ t);
            exp = cc ^ t;
            wait_sig({nm, "_dout_vld"}, 1);
            chk({nm, "_dout"}, o_dout, exp);
            chk({nm, "_out_din_rdy"}, o_din_ready, 0);
            if (b == stall_blk) begin
                repeat (10) begin
                    @(negedge i_clk);
                    chk({nm, "_stall_dout"}, o_dout, exp);
                    chk({nm, "_stall_vld"}, o_dout_valid, 1);
                    chk({nm, "_stall_din_rdy"}, o_din_ready, 0);
                    chk({nm, "_stall_cstart"}, o_core_start, 0);
                end
            end
            if (b == nbe - 1) chk({nm, "_early_done"}, done_cnt, d0);
            i_dout_ready = 1'b1;
            @(negedge i_clk);
            i_dout_ready = 1'b0;
            t = ref_dbl(t);
        end
        for (int i = 0; i < 10 && o_busy; i++) @(negedge i_clk);
        chk({nm, "_idle"}, o_busy, 0);
        chk({nm, "_done_cnt"}, done_cnt, d0 + 1);
        chk({nm, "_key_pulses"}, kv_cnt, k0 + 2);
        chk({nm, "_end_din_rdy"}, o_din_ready, 0);
    endtask

    task automatic reset_mid_unit();
        int d0;
        int dv_seen;
        @(negedge i_clk);
        i_start = 1'b1; i_decrypt = 1'b0; i_key = KEY_A; i_tweak = TW_B; i_nblocks = 6'd2;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_sig("rm_din_rdy", 0);
        i_din = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10; i_din_valid = 1'b1;
        @(negedge i_clk);
        i_din_valid = 1'b0;
        chk("rm_cstart", o_core_start, 1);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        check_zero("rm");
        i_rst = 1'b0;
        d0 = done_cnt;
        dv_seen = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_dout_valid || o_busy || o_din_ready) dv_seen++;
        end
        chk("rm_late_core", dv_seen, 0);
        chk("rm_no_done", done_cnt, d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge i_clk);
        check_zero("rst");
        i_rst = 1'b0;

        gf_in = 128'h0100_0000_0000_0000_0000_0000_0000_0000;
        #1 chk("gf_byte0", gf_out, 128'h0200_0000_0000_0000_0000_0000_0000_0000);
        gf_in = 128'h0000_0000_0000_0000_0000_0000_0000_0080;
        #1 chk("gf_wrap", gf_out, 128'h8700_0000_0000_0000_0000_0000_0000_0000);
        gf_in = 128'h0;
        #1 chk("gf_zero", gf_out, 128'h0);
        gf_in = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        #1 chk("gf_carry", gf_out, 128'h0001_0000_0000_0000_0000_0000_0000_0000);

        run_unit("u1", 1'b0, KEY_A, TW_A, 6'd3, 1, 1'b0);
        run_unit("u2", 1'b1, KEY_B, TW_B, 6'd0, -1, 1'b0);
        run_unit("u3", 1'b0, KEY_B, TW_A, 6'd2, -1, 1'b1);
        reset_mid_unit();
        run_unit("u4", 1'b1, KEY_A, TW_B, 6'd1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
